// File: rtl/imem_loader.sv
// Byte-stream program loader: length header + little-endian instruction words into instruction memory.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked before the image is accepted.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM  = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER = S_CSUM;
`else
    localparam state_t S_AFTER = S_DONE;
`endif
    localparam logic [32:0] CAP = 33'd1 << ADDR_W;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                we_q, done_q, error_q, hold_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [31:0]         wdata_q;
    logic [ADDR_W:0]     ww_q;
    logic [1:0]          byte_cnt_q;
    logic [31:0]         len_q;
    logic [23:0]         word_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif
    logic                accept_s, start_ok_s, last_word_s;
    logic [31:0]         len_full_s;

    // Next-state decode; in_ready depends only on the registered state.
    always_comb begin
        state_d     = state_q;
        start_ok_s  = 1'b0;
        accept_s    = in_valid && ready_q;
        len_full_s  = {in_data, len_q[23:0]};
        last_word_s = (({{(31-ADDR_W){1'b0}}, ww_q} + 32'd1) == len_q);
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    start_ok_s = 1'b1;
                    state_d    = S_LEN;
                end else begin
                    state_d    = state_q;
                end
            end
            S_LEN: begin
                if (accept_s && (byte_cnt_q == 2'd3)) begin
                    if (len_full_s == 32'd0) begin
                        state_d = S_AFTER;
                    end else if ({1'b0, len_full_s} > CAP) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DATA: begin
                if (accept_s && (byte_cnt_q == 2'd3) && last_word_s) begin
                    state_d = S_AFTER;
                end else begin
                    state_d = state_q;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept_s) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_LEN, S_DATA: ready_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:        ready_d = 1'b1;
`endif
            default:       ready_d = 1'b0;
        endcase
    end

    // State, registered outputs and byte/word assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            hold_q     <= 1'b1;
            waddr_q    <= '0;
            wdata_q    <= 32'd0;
            ww_q       <= '0;
            byte_cnt_q <= 2'd0;
            len_q      <= 32'd0;
            word_q     <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= (state_d == S_DONE);
            error_q <= (state_d == S_ERROR);
            // Release the core only once DONE has been visible for a full cycle.
            hold_q  <= !((state_q == S_DONE) && (state_d == S_DONE));
            we_q    <= 1'b0;
            if (start_ok_s) begin
                byte_cnt_q <= 2'd0;
                ww_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum_q     <= 8'd0;
`endif
            end else if (accept_s) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                if (state_q == S_LEN) begin
                    len_q[{byte_cnt_q, 3'b000} +: 8] <= in_data;
                end else if (state_q == S_DATA) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_q <= csum_q ^ in_data;
`endif
                    case (byte_cnt_q)
                        2'd0:    word_q[7:0]   <= in_data;
                        2'd1:    word_q[15:8]  <= in_data;
                        2'd2:    word_q[23:16] <= in_data;
                        default: begin
                            we_q    <= 1'b1;
                            wdata_q <= {in_data, word_q};
                            waddr_q <= ADDR_W'(BASE_ADDR) + ww_q[ADDR_W-1:0];
                            ww_q    <= ww_q + 1'b1;
                        end
                    endcase
                end else begin
                    len_q <= len_q;
                end
            end else begin
                byte_cnt_q <= byte_cnt_q;
            end
        end
    end

    assign in_ready      = ready_q;
    assign imem_we       = we_q;
    assign imem_waddr    = waddr_q;
    assign imem_wdata    = wdata_q;
    assign core_hold     = hold_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default build; LOADER_CHECKSUM_EN adds checksum cases).
module tb_imem_loader;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, imem_we, core_hold, done, error;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_written;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    logic [7:0]        prog[12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                                    8'h93, 8'h00, 8'h10, 8'h00,
                                    8'h13, 8'h01, 8'h20, 8'h00};

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_hold(core_hold), .done(done), .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    // Write monitor: log every memory write strobe mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_waddr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int n = 0;
        if (gap) begin
            in_valid = 1'b0;
            step();
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
        else step();
    endtask

    task automatic run_prog(input bit gap, input logic [7:0] csum, input int from);
        for (int i = from; i < 12; i++) send(prog[i], gap);
`ifdef LOADER_CHECKSUM_EN
        send(csum, gap);
`endif
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_hold"}, core_hold, 1);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_we"}, imem_we, 0);
        chk({tag, "_waddr"}, imem_waddr, 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_ww"}, words_written, 0);
    endtask

    task automatic chk_two_writes(input string tag, input int base);
        chk({tag, "_nwr"}, wr_addr.size() - base, 2);
        if (wr_addr.size() >= base + 2) begin
            chk({tag, "_a0"}, wr_addr[base], 0);
            chk({tag, "_d0"}, wr_data[base], 32'h00100093);
            chk({tag, "_a1"}, wr_addr[base+1], 1);
            chk({tag, "_d1"}, wr_data[base+1], 32'h00200113);
        end
    endtask

    initial begin
        int base;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) step();
        chk_reset_outs("rst");
        rst_n = 1'b1;
        step();

        // First load, back-to-back bytes.
        base = wr_addr.size();
        pulse_start();
        chk("start_ready", in_ready, 1);
        run_prog(1'b0, 8'hB1, 0);
`ifndef LOADER_CHECKSUM_EN
        chk("last_we", imem_we, 1);
`endif
        chk("l1_done", done, 1);
        chk("l1_ww", words_written, 2);
        chk("l1_hold_still", core_hold, 1);
        in_valid = 1'b0;
        step();
        chk("l1_we_pulse", imem_we, 0);
        chk("l1_hold_fall", core_hold, 0);
        chk_two_writes("l1", base);

        // Restart after DONE, then the same load with idle gaps.
        pulse_start();
        chk("rs_done", done, 0);
        chk("rs_ww", words_written, 0);
        chk("rs_hold", core_hold, 1);
        base = wr_addr.size();
        run_prog(1'b1, 8'hB1, 0);
        chk("l2_done", done, 1);
        chk("l2_ww", words_written, 2);
        in_valid = 1'b0;
        step();
        chk_two_writes("l2", base);

        // Zero length.
        base = wr_addr.size();
        pulse_start();
        for (int i = 0; i < 4; i++) send(8'h00, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send(8'h00, 1'b0);
`endif
        in_valid = 1'b0;
        step();
        chk("len0_done", done, 1);
        chk("len0_nwr", wr_addr.size() - base, 0);

        // Over-capacity length 1025.
        pulse_start();
        send(8'h01, 1'b0); send(8'h04, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        step();
        chk("len1025_err", error, 1);
        chk("len1025_hold", core_hold, 1);
        chk("len1025_ready", in_ready, 0);
        chk("len1025_nwr", wr_addr.size() - base, 0);
        in_valid = 1'b0;

        // Start ignored in DATA: stop after two data bytes, pulse start, finish the load.
        pulse_start();
        chk("err_clear", error, 0);
        base = wr_addr.size();
        for (int i = 0; i < 6; i++) send(prog[i], 1'b0);
        in_valid = 1'b0;
        pulse_start();
        chk("mid_ready", in_ready, 1);
        run_prog(1'b0, 8'hB1, 6);
        in_valid = 1'b0;
        step();
        chk("mid_done", done, 1);
        chk_two_writes("mid", base);

        // Exact capacity 1024 is accepted into DATA; reset mid-load afterwards.
        pulse_start();
        send(8'h00, 1'b0); send(8'h04, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        in_valid = 1'b0;
        chk("len1024_ready", in_ready, 1);
        chk("len1024_err", error, 0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();

        pulse_start();
        send(8'h04, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        for (int i = 4; i < 10; i++) send(prog[i], 1'b0);
        chk("rml_ww", words_written, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rml");
        base = wr_addr.size();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();
        in_valid = 1'b0;
        chk("rml_nwr", wr_addr.size() - base, 0);
        chk("rml_idle_ready", in_ready, 0);
        chk("rml_idle_hold", core_hold, 1);

`ifdef LOADER_CHECKSUM_EN
        pulse_start();
        run_prog(1'b0, 8'hB0, 0);
        in_valid = 1'b0;
        step();
        chk("csum_bad_err", error, 1);
        chk("csum_bad_hold", core_hold, 1);
        chk("csum_bad_done", done, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes the instruction memory the single-cycle core fetches from. It accepts a little-endian length header and instruction bytes over a valid/ready byte handshake, assembles 32-bit words and issues one write per word to the instruction memory write port. It holds the core in its stalled state until the image is complete, so the core never fetches a partially written program.

## Interface
- ADDR_W, 10: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- BASE_ADDR, 0: word address of the first loaded word.

Ports:
- clk  in  1: single clock.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: single-cycle pulse that begins a load.
- in_valid  in  1: byte available on in_data.
- in_data  in  8: stream byte.
- in_ready  out  1: loader accepts a byte. A transfer occurs on a rising edge where in_valid && in_ready.
- imem_we  out  1: single-cycle instruction-memory write strobe.
- imem_waddr  out  ADDR_W: word address of the write.
- imem_wdata  out  32: word to write.
- core_hold  out  1: keeps the core stalled while high.
- done  out  1: level; the image has loaded successfully.
- error  out  1: level, sticky; the load failed.
- words_written  out  ADDR_W+1: count of words written in the current load.

## Operation
- States:
  - IDLE: entered by reset.
  - LEN: collects the 4 length bytes.
  - DATA: collects instruction bytes.
  - CSUM: checksum byte; exists only with the macro.
  - DONE: load complete.
  - ERROR: load failed.
- start handling:
  - start in IDLE, DONE or ERROR moves to LEN, clears done, error, words_written and the byte counter, and sets core_hold.
  - start in LEN, DATA or CSUM is ignored.
- LEN:
  - Accepts 4 bytes, LSB first, into N (32 bits).
  - After the 4th byte, the next state is chosen as follows:
    - N == 0 → DONE (or CSUM with the macro).
    - N > 2^ADDR_W → ERROR.
    - Otherwise → DATA.
- DATA:
  - Byte k of a word fills bits [8k+7:8k]; the stream is little-endian.
  - On acceptance of the 4th byte, the loader registers a write: imem_wdata = the word, imem_waddr = (BASE_ADDR + index) mod 2^ADDR_W, and words_written increments.
  - After word N−1 the state moves to DONE, or to CSUM with the macro.
- in_ready is 1 in LEN, DATA and CSUM, and 0 otherwise. Bytes presented in other states are not consumed.
- DONE:
  - done = 1.
  - core_hold falls one cycle after done rises.
  - The loader stays in DONE until the next start.
- ERROR:
  - error = 1 and core_hold stays 1.
  - The loader stays in ERROR until the next start.
- Reset: every output and register returns to its reset value at once, including mid-load. Words already written remain in memory.

## Timing
- Reset values:
  - core_hold = 1.
  - in_ready, imem_we, done, error = 0.
  - imem_waddr, imem_wdata, words_written = 0.
  - state = IDLE.
- in_ready is 1 in the cycle after the start pulse. There is no combinational path from in_valid to in_ready.
- Write latency: imem_we is high for exactly one cycle. That cycle immediately follows the edge that accepted the 4th byte.
- Throughput: 1 byte per cycle when in_valid is held high. Gaps in in_valid only stall progress.
- The final word's imem_we and the rise of done (or the entry to CSUM) occur in the same cycle.
- core_hold is 0 no earlier than one cycle after the final imem_we.
- words_written updates in the same cycle as imem_we.

## Configuration
- LOADER_CHECKSUM_EN:
  - Defined:
    - After the last word (or after a zero length), one checksum byte is accepted in CSUM.
    - The checksum is the XOR of all data bytes; length bytes are excluded, and the checksum is 0 when N = 0.
    - Match → DONE. Mismatch → ERROR. Data words already written stay in memory.
  - Undefined:
    - The CSUM state does not exist.
    - The loader goes from the last word (or N = 0) directly to DONE.
    - No extra byte is consumed.

## Test plan
- Reset values and first load:
  - Stimulus: assert rst_n = 0, release it, then pulse start and stream 02 00 00 00, 93 00 10 00, 13 01 20 00 back-to-back.
  - Required response:
    - While rst_n is low: core_hold = 1 and all other outputs = 0.
    - After start: two imem_we pulses, at addresses BASE and BASE+1, with data 0x00100093 and 0x00200113.
    - words_written = 2, done = 1, then core_hold = 0 on the next cycle.
- Backpressure and idle gaps:
  - Stimulus: repeat the two-word load with in_valid toggling every other cycle.
  - Required response: identical memory writes, words_written = 2 and done = 1; only the timing is stretched.
- Boundary lengths:
  - Stimulus: length 0; then length 2^ADDR_W + 1 = 1025 with ADDR_W = 10.
  - Required response:
    - Length 0: done = 1 and no imem_we.
    - Length 1025: error = 1, core_hold stays 1, no writes, and in_ready = 0.
- Restart and ignored start:
  - Stimulus: pulse start in the middle of DATA, then pulse start again after the load reaches DONE.
  - Required response:
    - The mid-DATA start has no effect.
    - The post-DONE start clears done and words_written and raises core_hold.
- Reset mid-load:
  - Stimulus: assert rst_n low after 1.5 words of a 4-word load.
  - Required response: outputs return to their reset values immediately, no further writes occur, and state = IDLE.
- LOADER_CHECKSUM_EN:
  - Stimulus: the two-word load followed by the correct checksum byte, then again followed by that byte ^ 0x01.
  - Required response: the correct checksum gives done = 1; the corrupted checksum gives error = 1 with core_hold = 1.
